// File: rtl/ptp_irq_ctrl.sv
// Interrupt controller for the xge-ptpv2 core: per-source edge/level capture into
// sticky W1C status, masked into one registered line with a re-assertion holdoff.

module ptp_irq_src #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic level_mode,
    input  logic set_req,
    input  logic clr_req,
    output logic raw,
    output logic status
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic                   rise;
    logic                   set;

    assign raw  = chain[SYNC_STAGES-1];
    assign rise = raw & ~prev;
    assign set  = (level_mode ? raw : rise) | set_req;

    // A set condition in the same cycle as a clear keeps the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= '0;
            prev   <= 1'b0;
            status <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], src};
            prev   <= raw;
            status <= set | (status & ~clr_req);
        end
    end
endmodule

module ptp_irq_ctrl #(
    parameter int                  NUM_SRC       = 3,
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [31:0]         INT_BASE_ADDR = 32'h300,
    parameter logic [NUM_SRC-1:0]  MASK_RST      = {NUM_SRC{1'b1}}
) (
    input  logic               bus2ip_clk,
    input  logic               bus2ip_rst_n,
    input  logic [31:0]        bus2ip_addr_i,
    input  logic [31:0]        bus2ip_data_i,
    input  logic               bus2ip_rd_ce_i,
    input  logic               bus2ip_wr_ce_i,
    output logic [31:0]        ip2bus_data_o,
    input  logic [NUM_SRC-1:0] int_src_i,
    output logic               int_ptp_o
);
    localparam logic [31:0] A_STATUS  = INT_BASE_ADDR;
    localparam logic [31:0] A_MASK    = INT_BASE_ADDR + 32'd1;
    localparam logic [31:0] A_TYPE    = INT_BASE_ADDR + 32'd2;
    localparam logic [31:0] A_RAW     = INT_BASE_ADDR + 32'd3;
    localparam logic [31:0] A_PENDING = INT_BASE_ADDR + 32'd4;
    localparam logic [31:0] A_SET     = INT_BASE_ADDR + 32'd5;
    localparam logic [31:0] A_HOLDOFF = INT_BASE_ADDR + 32'd6;

    logic [NUM_SRC-1:0] status;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] level_mode;
    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] pending;
    logic [15:0]        holdoff;
    logic [15:0]        cnt;
    logic               wr_status;
    logic               wr_mask;
    logic               wr_type;
    logic               wr_set;
    logic               wr_holdoff;
    logic [31:0]        rdata;
    logic               data_unused;

    assign data_unused = &{1'b0, bus2ip_data_i[31:16]};

    assign wr_status  = bus2ip_wr_ce_i && (bus2ip_addr_i == A_STATUS);
    assign wr_mask    = bus2ip_wr_ce_i && (bus2ip_addr_i == A_MASK);
    assign wr_type    = bus2ip_wr_ce_i && (bus2ip_addr_i == A_TYPE);
    assign wr_set     = bus2ip_wr_ce_i && (bus2ip_addr_i == A_SET);
    assign wr_holdoff = bus2ip_wr_ce_i && (bus2ip_addr_i == A_HOLDOFF);

    assign pending = status & mask;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        ptp_irq_src #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_src (
            .clk        (bus2ip_clk),
            .rst_n      (bus2ip_rst_n),
            .src        (int_src_i[i]),
            .level_mode (level_mode[i]),
            .set_req    (wr_set & bus2ip_data_i[i]),
            .clr_req    (wr_status & bus2ip_data_i[i]),
            .raw        (raw[i]),
            .status     (status[i])
        );
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            mask       <= MASK_RST;
            level_mode <= '0;
            holdoff    <= '0;
        end else begin
            if (wr_mask)    mask       <= bus2ip_data_i[NUM_SRC-1:0];
            if (wr_type)    level_mode <= bus2ip_data_i[NUM_SRC-1:0];
            if (wr_holdoff) holdoff    <= bus2ip_data_i[15:0];
        end
    end

    // Holdoff starts when an asserted line loses its last pending bit; a
    // HOLDOFF write only affects the next load, never a running count.
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            cnt       <= '0;
            int_ptp_o <= 1'b0;
        end else begin
            if (int_ptp_o && (pending == '0)) cnt <= holdoff;
            else if (cnt != 16'd0)            cnt <= cnt - 16'd1;
            int_ptp_o <= (|pending) && (cnt == 16'd0);
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (bus2ip_rd_ce_i) begin
            case (bus2ip_addr_i)
                A_STATUS:  rdata = 32'(status);
                A_MASK:    rdata = 32'(mask);
                A_TYPE:    rdata = 32'(level_mode);
                A_RAW:     rdata = 32'(raw);
                A_PENDING: rdata = 32'(pending);
                A_HOLDOFF: rdata = {16'h0, holdoff};
                default:   rdata = 32'h0;
            endcase
        end
    end

    assign ip2bus_data_o = rdata;
endmodule

// File: tb/tb_ptp_irq_ctrl.sv
// Bench for ptp_irq_ctrl: directed scenarios followed by random bus and source
// traffic, all checked against a cycle-level behavioural model.

module tb_ptp_irq_ctrl;
    localparam int          NS   = 3;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h300;

    logic          clk;
    logic          rst_n;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          rd_ce;
    logic          wr_ce;
    logic [31:0]   rdata;
    logic [NS-1:0] src;
    logic          irq;

    int n_chk = 0;
    int n_err = 0;

    logic [NS-1:0] m_status, m_mask, m_type;
    logic [15:0]   m_hold, m_cnt;
    logic          m_int;
    logic [NS-1:0] hist [0:S];

    ptp_irq_ctrl #(
        .NUM_SRC       (NS),
        .SYNC_STAGES   (S),
        .INT_BASE_ADDR (BASE),
        .MASK_RST      (3'b111)
    ) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst_n   (rst_n),
        .bus2ip_addr_i  (addr),
        .bus2ip_data_i  (wdata),
        .bus2ip_rd_ce_i (rd_ce),
        .bus2ip_wr_ce_i (wr_ce),
        .ip2bus_data_o  (rdata),
        .int_src_i      (src),
        .int_ptp_o      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = '0;
        m_mask   = '1;
        m_type   = '0;
        m_hold   = '0;
        m_cnt    = '0;
        m_int    = 1'b0;
        for (int k = 0; k <= S; k++) hist[k] = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == BASE)             return 32'(m_status);
        else if (a == BASE + 32'd1) return 32'(m_mask);
        else if (a == BASE + 32'd2) return 32'(m_type);
        else if (a == BASE + 32'd3) return 32'(hist[S-1]);
        else if (a == BASE + 32'd4) return 32'(m_status & m_mask);
        else if (a == BASE + 32'd6) return {16'h0, m_hold};
        return 32'h0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [NS-1:0] lvl, old, rise, setv, clrv, pend;
        logic          nxt_int;
        lvl  = hist[S-1];
        old  = hist[S];
        rise = lvl & ~old;
        setv = (m_type & lvl) | (~m_type & rise);
        clrv = '0;
        pend = m_status & m_mask;
        if (wr_ce && addr == BASE + 32'd5) setv |= wdata[NS-1:0];
        if (wr_ce && addr == BASE)         clrv  = wdata[NS-1:0];
        nxt_int = (pend != '0) && (m_cnt == 16'd0);
        if (m_int && pend == '0) m_cnt = m_hold;
        else if (m_cnt != 16'd0) m_cnt = m_cnt - 16'd1;
        m_int    = nxt_int;
        m_status = setv | (m_status & ~clrv);
        if (wr_ce && addr == BASE + 32'd1) m_mask = wdata[NS-1:0];
        if (wr_ce && addr == BASE + 32'd2) m_type = wdata[NS-1:0];
        if (wr_ce && addr == BASE + 32'd6) m_hold = wdata[15:0];
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = src;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("irq", 32'(irq), 32'(m_int));
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        addr  = BASE + 32'(off);
        wdata = d;
        wr_ce = 1'b1;
        tick();
        wr_ce = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic rd(input int off);
        addr  = BASE + 32'(off);
        rd_ce = 1'b1;
        #1;
        chk($sformatf("rd+%0d", off), rdata, m_read(addr));
        rd_ce = 1'b0;
        addr  = 32'h0;
    endtask

    task automatic rd_lit(input string tag, input int off, input logic [31:0] exp);
        addr  = BASE + 32'(off);
        rd_ce = 1'b1;
        #1;
        chk(tag, rdata, exp);
        rd_ce = 1'b0;
        addr  = 32'h0;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        rd_ce = 1'b0;
        wr_ce = 1'b0;
        src   = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata_idle", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_lit("rst_mask", 1, 32'h7);
        rd_lit("rst_status", 0, 32'h0);
        rd_lit("rst_type", 2, 32'h0);
        rd_lit("rst_holdoff", 6, 32'h0);

        // Edge mode on source 1
        src = 3'b010;
        tick();
        src = 3'b000;
        tick();
        tick();
        rd_lit("edge_status", 0, 32'h2);
        tick();
        chk("edge_irq", 32'(irq), 32'h1);
        wr(0, 32'h2);
        rd_lit("edge_clr", 0, 32'h0);
        tick();
        chk("edge_irq_clr", 32'(irq), 32'h0);

        // Level mode on source 0
        wr(2, 32'h1);
        src = 3'b001;
        repeat (3) tick();
        wr(0, 32'h1);
        rd_lit("lvl_hold", 0, 32'h1);
        src = 3'b000;
        repeat (3) tick();
        wr(0, 32'h1);
        rd_lit("lvl_clr", 0, 32'h0);
        tick();

        // Masking
        wr(2, 32'h0);
        wr(1, 32'h0);
        src = 3'b111;
        tick();
        src = 3'b000;
        repeat (4) tick();
        rd_lit("msk_status", 0, 32'h7);
        rd_lit("msk_pending", 4, 32'h0);
        chk("msk_irq", 32'(irq), 32'h0);
        wr(1, 32'h4);
        rd_lit("msk_pending4", 4, 32'h4);
        tick();
        chk("msk_irq_on", 32'(irq), 32'h1);
        wr(0, 32'h7);
        wr(1, 32'h7);
        tick();

        // Holdoff coalescing
        wr(6, 32'd10);
        wr(5, 32'h1);
        tick();
        chk("ho_irq", 32'(irq), 32'h1);
        wr(0, 32'h1);
        wr(5, 32'h1);
        k = 0;
        while (irq == 1'b0 && k < 50) begin
            tick();
            k++;
        end
        chk("ho_delay", 32'(k), 32'd11);

        // Set wins over clear on a coincident rise
        src = 3'b100;
        tick();
        tick();
        wr(0, 32'h4);
        rd_lit("sim_set_wins", 0, 32'h5);
        src = 3'b000;
        wr(0, 32'h1);
        k = 0;
        while (irq == 1'b0 && k < 50) begin
            tick();
            k++;
        end
        chk("sim_irq_wait", 32'(k < 50), 32'h1);
        wr(0, 32'h4);
        tick();
        tick();

        // Reset during a holdoff count
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_irq", 32'(irq), 32'h0);
        rd_lit("mid_rst_status", 0, 32'h0);
        rd_lit("mid_rst_holdoff", 6, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wr(5, 32'h2);
        tick();
        chk("mid_rst_cnt0", 32'(irq), 32'h1);
        wr(0, 32'h2);
        tick();

        // Random traffic
        for (int it = 0; it < 600; it++) begin
            int op, off;
            op  = $urandom_range(0, 9);
            off = $urandom_range(0, 8);
            if (op <= 3) begin
                src = ($urandom_range(0, 3) == 0) ? NS'($urandom) : src;
                tick();
            end else if (op <= 6) begin
                if (off == 6)      wr(off, $urandom & 32'hF);
                else if (off == 0) wr(off, $urandom & $urandom);
                else               wr(off, $urandom);
            end else begin
                rd(off);
                tick();
            end
        end
        src = '0;
        repeat (6) tick();
        for (int o = 0; o < 8; o++) rd(o);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ptp_irq_ctrl.md
Name: ptp_irq_ctrl

Overview:
Parametrised interrupt controller for the xge-ptpv2 core. It aggregates NUM_SRC asynchronous interrupt sources into one registered interrupt line on the 32-bit on-chip bus. Each source has a per-source edge or level mode. Status is sticky and write-1-to-clear, with a software set register and a holdoff (coalescing) timer that rate-limits re-assertion of the output.

Parameters:
NUM_SRC, 3, number of interrupt sources (1..32)
SYNC_STAGES, 2, synchroniser flops per source (2..4)
INT_BASE_ADDR, 32'h300, word address of register 0
MASK_RST, {NUM_SRC{1'b1}}, reset value of MASK

Ports:
bus2ip_clk  in  1  bus clock
bus2ip_rst_n  in  1  asynchronous active-low reset
bus2ip_addr_i  in  32  word address
bus2ip_data_i  in  32  write data
bus2ip_rd_ce_i  in  1  read enable, active high
bus2ip_wr_ce_i  in  1  write enable, active high, one write per cycle
ip2bus_data_o  out  32  read data
int_src_i  in  NUM_SRC  raw interrupt sources, asynchronous
int_ptp_o  out  1  combined interrupt, registered, active high

Behaviour:
- Clock and reset: one clock, bus2ip_clk. Reset bus2ip_rst_n is asynchronous and active-low. Reset clears all flops except MASK, which loads MASK_RST. int_ptp_o=0, ip2bus_data_o=0 at reset.
- Register map (full 32-bit address compare; only bits [NUM_SRC-1:0] are meaningful; unused bits read 0):
  - +0 STATUS: RW1C, sticky.
  - +1 MASK: RW, 1 = enabled.
  - +2 TYPE: RW, reset 0. 0 = rising edge, 1 = level-high.
  - +3 RAW: RO, synchronised input levels.
  - +4 PENDING: RO, STATUS & MASK.
  - +5 SET: WO, reads 0. Writing 1 sets the STATUS bit.
  - +6 HOLDOFF: RW, bits [15:0], reset 0.
  - Writes to RO or unmapped addresses are ignored.
- Read path is combinational: ip2bus_data_o = selected register when bus2ip_rd_ce_i=1 and the address hits, else 32'h0. Reads have no side effects; there is no read-clear.
- Synchronisation: each source passes through a SYNC_STAGES flop chain, then one extra delay flop (prev). rise = sync_last & ~prev.
- Status set conditions per bit i, evaluated each cycle:
  - TYPE[i]=0: set on rise.
  - TYPE[i]=1: set every cycle sync_last is 1.
  - SET write with data[i]=1: set.
- Status clear: STATUS write with data[i]=1 clears bit i, unless a set condition for bit i is true in the same cycle (set wins). A level source therefore cannot be cleared while its input is still high.
- Latency, SYNC_STAGES=2:
  - Input high before edge 1 -> STATUS set at edge 3 -> int_ptp_o at edge 4.
  - SET write at edge n -> STATUS at edge n -> int_ptp_o at edge n+1.
- Holdoff counter (16 bits):
  - int_ptp_o <= (|PENDING) & (cnt==0).
  - When int_ptp_o=1 and PENDING becomes 0, cnt loads HOLDOFF at that edge.
  - While cnt!=0, cnt decrements by 1 per cycle.
  - HOLDOFF=0 disables the holdoff.
  - Writing HOLDOFF does not affect a running count; the new value applies at the next load.
  - Pending bits arriving during holdoff are held in STATUS; int_ptp_o asserts on the cycle after cnt reaches 0.
- Changing MASK or TYPE takes effect at the next edge. Clearing a MASK bit drops int_ptp_o within 1 cycle if no other bit is pending; the STATUS bit is retained.
- Reset mid-operation aborts the holdoff count and clears all status immediately.

Test Plan:
1. Reset, then read +1 -> 0x7; read +0, +2, +6 -> 0; int_ptp_o=0.
2. Edge mode: pulse int_src_i[1] for 1 cycle -> STATUS=0x2 three cycles later, int_ptp_o=1 one cycle after that. Write 0x2 to +0 -> STATUS=0, int_ptp_o=0 next cycle.
3. Level mode: TYPE=0x1, hold int_src_i[0]=1, write 0x1 to +0 -> STATUS remains 0x1. Drop the input, wait 3 cycles, write 0x1 -> STATUS=0.
4. Masking: MASK=0x0, pulse all sources -> STATUS=0x7, PENDING=0, int_ptp_o stays 0. Write MASK=0x4 -> PENDING=0x4, int_ptp_o=1 one cycle later.
5. Holdoff: HOLDOFF=10, raise and clear bit 0, then write SET=0x1 on the following cycle -> int_ptp_o stays 0 for 10 cycles after the clear, then asserts.
6. Simultaneous events: STATUS W1C of bit 2 in the same cycle as a rise on source 2 -> bit 2 remains 1. Assert reset during a holdoff count -> cnt=0, STATUS=0, int_ptp_o=0.
